// File: rtl/stimulus_sequencer_if.sv
// Bus between the stimulus sequencer and its controller/circuit under test.
// The master side drives the run request and returns f; the sequencer is the slave.
interface stimulus_sequencer_if #(
    parameter int WIDTH = 80,
    parameter int CNT_W = 16
);
    logic             start;
    logic             mode;
    logic [CNT_W-1:0] num_patterns;
    logic [WIDTH-1:0] vec_out;
    logic             f_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ones_count;
    logic [15:0]      signature;

    modport master (
        output start, mode, num_patterns, f_in,
        input  vec_out, busy, done, ones_count, signature
    );

    modport slave (
        input  start, mode, num_patterns, f_in,
        output vec_out, busy, done, ones_count, signature
    );
endinterface

// File: rtl/stimulus_sequencer.sv
// Applies counter or LFSR patterns to a combinational netlist and compacts its response f.
// Define STIM_RESP_PIPE_EN to register f before compaction (adds one DRAIN cycle per run).
module stimulus_sequencer #(
    parameter int               WIDTH = 80,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] SEED  = 80'h1
) (
    input logic                 clk,
    input logic                 rst,
    stimulus_sequencer_if.slave bus
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] vec_reg, vec_next;
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] n_reg, n_next;
    logic             mode_reg, mode_next;
    logic [CNT_W-1:0] ones_reg, ones_next;
    logic [15:0]      sig_reg, sig_next;

    logic [WIDTH-1:0] lfsr_next;
    logic             comp_en;
    logic             comp_bit;

    // Fibonacci LFSR, taps 80/79/43/42: shift up, feedback into bit 0.
    assign lfsr_next[0] = vec_reg[WIDTH-1] ^ vec_reg[WIDTH-2] ^ vec_reg[42] ^ vec_reg[41];
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = vec_reg[gi-1];
        end
    endgenerate

`ifdef STIM_RESP_PIPE_EN
    localparam state_t LAST_STATE = DRAIN;
    logic resp_reg;
    logic resp_vld_reg;

    // The sample taken on a RUN edge is compacted one edge later (in RUN or DRAIN).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_reg     <= 1'b0;
            resp_vld_reg <= 1'b0;
        end else begin
            resp_reg     <= bus.f_in;
            resp_vld_reg <= (state_reg == RUN);
        end
    end

    assign comp_en  = resp_vld_reg;
    assign comp_bit = resp_reg;
`else
    localparam state_t LAST_STATE = DONE;
    assign comp_en  = (state_reg == RUN);
    assign comp_bit = bus.f_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            idx_reg   <= '0;
            n_reg     <= '0;
            mode_reg  <= 1'b0;
            ones_reg  <= '0;
            sig_reg   <= '0;
        end else begin
            state_reg <= state_next;
            vec_reg   <= vec_next;
            idx_reg   <= idx_next;
            n_reg     <= n_next;
            mode_reg  <= mode_next;
            ones_reg  <= ones_next;
            sig_reg   <= sig_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        idx_next   = idx_reg;
        n_next     = n_reg;
        mode_next  = mode_reg;
        ones_next  = ones_reg;
        sig_next   = sig_reg;

        if (comp_en) begin
            if (comp_bit && (ones_reg != '1)) begin
                ones_next = ones_reg + CNT_W'(1);
            end
            sig_next = {sig_reg[14:0],
                        sig_reg[15] ^ sig_reg[13] ^ sig_reg[12] ^ sig_reg[10] ^ comp_bit};
        end

        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    n_next    = bus.num_patterns;
                    mode_next = bus.mode;
                    ones_next = '0;
                    sig_next  = '0;
                    idx_next  = '0;
                    if (bus.num_patterns == '0) begin
                        state_next = DONE;
                    end else begin
                        vec_next   = bus.mode ? SEED_EFF : '0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (idx_reg == n_reg - CNT_W'(1)) begin
                    state_next = LAST_STATE;
                end else begin
                    idx_next = idx_reg + CNT_W'(1);
                    vec_next = mode_reg ? lfsr_next : vec_reg + WIDTH'(1);
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.vec_out    = vec_reg;
    assign bus.busy       = (state_reg == RUN) || (state_reg == DRAIN);
    assign bus.done       = (state_reg == DONE);
    assign bus.ones_count = ones_reg;
    assign bus.signature  = sig_reg;

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Directed and random runs of stimulus_sequencer against a pattern-list reference model.
// Honours STIM_RESP_PIPE_EN for the expected latency.
module tb_stimulus_sequencer;

`ifdef STIM_RESP_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif
    localparam logic [79:0] SEED = 80'h1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;
    int run_id = 0;

    int          fsel = 0;
    logic [79:0] mask = '0;
    logic [79:0] last_vec = '0;

    stimulus_sequencer_if #(.WIDTH(80), .CNT_W(16)) bus ();

    stimulus_sequencer #(.WIDTH(80), .CNT_W(16), .SEED(SEED)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model of the circuit under test: several selectable response functions.
    function automatic logic cut(input int fs, input logic [79:0] v, input logic [79:0] mk);
        case (fs)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return v[0];
            default: return ^(v & mk);
        endcase
    endfunction

    assign bus.f_in = cut(fsel, bus.vec_out, mask);

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s run=%0d observed=%0h expected=%0h", tag, run_id, obs, exp);
        end
    endtask

    // Reference model: list of applied patterns and the compacted results.
    logic [79:0] pat[$];
    int          exp_ones;
    logic [15:0] exp_sig;

    task automatic build_model(input logic m, input int n, input int fs);
        logic [79:0] v;
        logic        f;
        pat.delete();
        exp_ones = 0;
        exp_sig  = 16'h0;
        v = m ? SEED : 80'h0;
        for (int k = 0; k < n; k++) begin
            pat.push_back(v);
            f = cut(fs, v, mask);
            if (f && exp_ones < 65535) exp_ones++;
            exp_sig = {exp_sig[14:0], exp_sig[15] ^ exp_sig[13] ^ exp_sig[12] ^ exp_sig[10] ^ f};
            if (m) v = {v[78:0], v[79] ^ v[78] ^ v[42] ^ v[41]};
            else   v = v + 80'h1;
        end
    endtask

    // One full run; mid > 0 pulses a different start request on that RUN cycle.
    task automatic run(input logic m, input int n, input int fs, input int mid);
        int          cyc;
        int          exp_cyc;
        logic [79:0] exp_vec;
        run_id++;
        fsel = fs;
        build_model(m, n, fs);
        exp_vec = (n == 0) ? last_vec : pat[n-1];
        exp_cyc = (n == 0) ? 1 : n + 1 + PIPE;

        @(negedge clk);
        bus.start        = 1'b1;
        bus.mode         = m;
        bus.num_patterns = 16'(n);
        @(negedge clk);
        bus.start        = 1'b0;
        bus.mode         = ~m;
        bus.num_patterns = 16'($urandom_range(1, 50));

        cyc = 1;
        while (bus.done !== 1'b1 && cyc <= n + 5) begin
            chk("busy_run", 80'(bus.busy), 80'h1);
            if (n > 0) chk("vec_run", bus.vec_out, (cyc <= n) ? pat[cyc-1] : pat[n-1]);
            bus.start = 1'b0;
            if (cyc == mid) begin
                bus.start        = 1'b1;
                bus.mode         = ~m;
                bus.num_patterns = 16'($urandom_range(1, 5));
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;

        chk("latency", 80'(cyc), 80'(exp_cyc));
        chk("done", 80'(bus.done), 80'h1);
        chk("busy_done", 80'(bus.busy), 80'h0);
        chk("ones", 80'(bus.ones_count), 80'(exp_ones));
        chk("sig", 80'(bus.signature), 80'(exp_sig));
        chk("vec_hold", bus.vec_out, exp_vec);
        last_vec = exp_vec;

        repeat (2) begin
            bus.mode         = 1'($urandom);
            bus.num_patterns = 16'($urandom);
            @(negedge clk);
        end
        chk("done_held", 80'(bus.done), 80'h1);
        chk("ones_held", 80'(bus.ones_count), 80'(exp_ones));
        chk("sig_held", 80'(bus.signature), 80'(exp_sig));

        $display("run %0d mode=%0d n=%0d fsel=%0d cycles=%0d ones=%0d sig=%04h",
                 run_id, m, n, fs, cyc, bus.ones_count, bus.signature);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start        = 1'b0;
        bus.mode         = 1'b0;
        bus.num_patterns = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_vec", bus.vec_out, 80'h0);
        chk("rst_ones", 80'(bus.ones_count), 80'h0);
        chk("rst_sig", 80'(bus.signature), 80'h0);
        chk("rst_busy", 80'(bus.busy), 80'h0);
        chk("rst_done", 80'(bus.done), 80'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_done", 80'(bus.done), 80'h0);

        // Counter N=4, f=1 (also the pipelined-build latency case)
        run(1'b0, 4, 1, 0);
        chk("t1_sig_const", 80'(bus.signature), 80'h000F);
        chk("t1_ones_const", 80'(bus.ones_count), 80'd4);

        // LFSR N=3, f=0
        run(1'b1, 3, 0, 0);
        chk("t2_vec_const", bus.vec_out, 80'h4);

        // N=0: straight to done with cleared results
        run(1'b0, 0, 1, 0);
        chk("t3_sig_zero", 80'(bus.signature), 80'h0);

        // Counter N=8, f=vec[0], start pulsed mid-run; then a second run replaces results
        run(1'b0, 8, 2, 3);
        chk("t4_ones_const", 80'(bus.ones_count), 80'd4);
        mask = {$urandom, $urandom, $urandom};
        run(1'b1, 8, 3, 0);

        // Asynchronous reset on the 3rd RUN cycle of an N=10 run
        run_id++;
        fsel = 1;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.mode         = 1'b0;
        bus.num_patterns = 16'd10;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_ones_pre", 80'(bus.ones_count), 80'(2 - PIPE));
        chk("t5_vec_pre", bus.vec_out, 80'h2);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_vec", bus.vec_out, 80'h0);
        chk("t5_rst_ones", 80'(bus.ones_count), 80'h0);
        chk("t5_rst_sig", 80'(bus.signature), 80'h0);
        chk("t5_rst_busy", 80'(bus.busy), 80'h0);
        chk("t5_rst_done", 80'(bus.done), 80'h0);
        $display("run %0d reset mid-run applied", run_id);
        @(negedge clk);
        rst = 1'b0;
        last_vec = '0;
        @(negedge clk);
        chk("t5_idle_done", 80'(bus.done), 80'h0);
        chk("t5_idle_busy", 80'(bus.busy), 80'h0);
        run(1'b0, 2, 1, 0);

        // Long LFSR run so feedback taps come into play
        mask = {$urandom, $urandom, $urandom};
        run(1'b1, 100, 3, 0);

        // Random runs
        for (int r = 0; r < 6; r++) begin
            mask = {$urandom, $urandom, $urandom};
            run(1'($urandom), $urandom_range(1, 40), $urandom_range(2, 3), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stimulus_sequencer.md
Name: stimulus_sequencer

Overview:
- Drives the 80-bit input vector (a0..a79) of a gate-level combinational circuit under test and compacts its single-bit response f.
- Applies N patterns per run, generated either by a binary counter or by an 80-bit LFSR.
- Samples f once per pattern and reports a ones count and a 16-bit serial signature.
- Sits directly upstream of the netlist: vec_out feeds the inputs, and f returns on f_in.

Parameters:
WIDTH, 80, stimulus vector width; bit i drives input a<i>
CNT_W, 16, width of num_patterns, the pattern index and ones_count
SEED, 80'h1, LFSR start value; a value of 0 is replaced by 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  run request; sampled only in IDLE or DONE
mode  input  1  0 = counter patterns, 1 = LFSR patterns; latched at start
num_patterns  input  CNT_W  patterns to apply; latched at start
vec_out  output  WIDTH  registered stimulus to the circuit under test
f_in  input  1  response f from the circuit under test
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE; held until the next accepted start
ones_count  output  CNT_W  number of sampled f_in == 1
signature  output  16  serial response signature

Behaviour:
- Reset, asynchronous: state = IDLE. vec_out, ones_count, signature, the pattern index and the latched N/mode all go to 0. busy = 0, done = 0.
- States are IDLE, RUN, DRAIN and DONE. DRAIN is used only with the optional feature enabled.
- IDLE/DONE + start:
  - Latch N = num_patterns and the mode.
  - Clear ones_count, signature and the index.
  - If N == 0: go to DONE with vec_out unchanged, so the next cycle shows done = 1 with zero results.
  - Otherwise: vec_out <= pattern0 (0 in counter mode, SEED in LFSR mode) and go to RUN.
- RUN, each cycle (k = index):
  - vec_out holds pattern k for the whole cycle; f_in is combinational from vec_out.
  - At the clock edge, f_in is compacted:
    - ones_count += f_in, saturating at all-ones.
    - signature <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]^f_in}.
  - If k == N-1: go to DONE (or DRAIN), and vec_out holds its last value.
  - Otherwise: index++ and vec_out <= next pattern.
- Pattern rules:
  - Counter mode: next = vec_out + 1, modulo 2^WIDTH.
  - LFSR mode: next = {v[78:0], v[79]^v[78]^v[42]^v[41]} (Fibonacci form, taps 80/79/43/42).
- Latency: exactly N RUN cycles from the start edge to entering DONE.
- start while busy is ignored. num_patterns and mode changes while busy have no effect.
- In DONE, ones_count and signature are stable and hold until the next accepted start.
- An asynchronous rst mid-run aborts the run immediately with no partial done.
- A start asserted in the same cycle as rst deasserting is ignored unless it is still high at a later edge.

Optional Feature:
- Macro: STIM_RESP_PIPE_EN.
- When defined:
  - f_in is registered once before compaction, for timing across a deep netlist.
  - The sample taken at the RUN edge of pattern k is compacted on the following edge.
  - After the last RUN cycle, the FSM spends one DRAIN cycle compacting the final registered sample, then enters DONE.
  - Total latency from start to DONE is N+1 cycles; the N == 0 case skips DRAIN.
- When undefined: no response register, DRAIN is unreachable, and latency is N cycles.

Test Plan:
1. Counter mode, N=4, f_in tied 1 -> vec_out steps 0,1,2,3; done after 4 cycles; ones_count=4; signature=16'h000F.
2. LFSR mode, SEED=1, N=3, f_in tied 0 -> vec_out steps 1,2,4; ones_count=0; signature=16'h0000; done held until next start.
3. N=0 start -> done=1 on the next cycle; busy never rises; ones_count=0; signature=0.
4. Counter mode, N=8, f_in = vec_out[0] (bench model) -> ones_count=4; a start pulsed mid-run is ignored; the second run's results replace the first's.
5. rst asserted on the 3rd RUN cycle of an N=10 run -> all outputs 0 asynchronously; a later start with N=2 completes normally with the correct results.
6. STIM_RESP_PIPE_EN defined, counter mode, N=4, f_in tied 1 -> DRAIN seen for one cycle; done at start+5; ones_count=4; signature=16'h000F.
